wave_channel_scheduler: RTL and testbench

- Time-shares one sine datapath (phase accumulate, CORDIC convergence, iterative CORDIC) among N_CH independent tone channels.
- Holds per-channel phase accumulators and amplitudes. On each sample tick, issues one job per enabled channel in ascending index order, waits for each result and stores it per channel.
- Sits between the sample-rate timer/config interface and the shared CORDIC datapath. The datapath receives absolute phase, so its internal accumulator is bypassed.

---
 rtl/wave_channel_scheduler.sv | 219 +++++++++++++++++++++
 tb/tb_wave_channel_scheduler.sv | 342 ++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/wave_channel_scheduler.sv
// Time-shares one CORDIC sine datapath among N_CH tone channels, one job per enabled channel per tick.
// Optional WAIT watchdog is enabled by defining WAVE_SCHED_TIMEOUT_EN.
module wave_channel_scheduler #(
  parameter int unsigned N_FRAC  = 7,
  parameter int unsigned N_CH    = 4,
  parameter int unsigned TIMEOUT = 31
) (
  input  logic                        clk_i,
  input  logic                        rst_i,
  input  logic                        sample_tick_i,
  input  logic [N_CH-1:0]             ch_enable_i,
  input  logic                        cfg_we_i,
  input  logic [2:0]                  cfg_ch_i,
  input  logic [N_FRAC:0]             cfg_phase_inc_i,
  input  logic [N_FRAC:0]             cfg_amplitude_i,
  input  logic                        cfg_phase_clr_i,
  input  logic                        overrun_clr_i,
  output logic [N_FRAC:0]             dp_phase_o,
  output logic [N_FRAC:0]             dp_amplitude_o,
  output logic                        dp_start_strobe_o,
  input  logic [N_FRAC:0]             dp_data_i,
  input  logic                        dp_valid_strobe_i,
  output logic [N_CH*(N_FRAC+1)-1:0]  ch_data_o,
  output logic                        frame_done_strobe_o,
  output logic                        busy_o,
  output logic                        overrun_o,
  output logic                        timeout_o
);

  localparam int unsigned W  = N_FRAC + 1;
  localparam int unsigned PW = $clog2(N_CH);

  localparam logic [1:0] StIdle  = 2'd0;
  localparam logic [1:0] StIssue = 2'd1;
  localparam logic [1:0] StWait  = 2'd2;
  localparam logic [1:0] StDone  = 2'd3;

  if (N_CH < 2 || N_CH > 8) begin : g_bad_n_ch
    $error("wave_channel_scheduler: N_CH must be in 2..8");
  end
  if (TIMEOUT < 1) begin : g_bad_timeout
    $error("wave_channel_scheduler: TIMEOUT must be at least 1");
  end

  logic [1:0]    state_q, state_d;
  logic [N_CH-1:0] en_q, en_d;
  logic [PW-1:0] ptr_q, ptr_d;
  logic [W-1:0]  acc_q  [N_CH];
  logic [W-1:0]  acc_d  [N_CH];
  logic [W-1:0]  inc_q  [N_CH];
  logic [W-1:0]  inc_d  [N_CH];
  logic [W-1:0]  amp_q  [N_CH];
  logic [W-1:0]  amp_d  [N_CH];
  logic [W-1:0]  data_q [N_CH];
  logic [W-1:0]  data_d [N_CH];
  logic [W-1:0]  phase_q, phase_d;
  logic [W-1:0]  ampl_q, ampl_d;
  logic          overrun_q, overrun_d;

  logic [PW-1:0] first_idx, next_idx;
  logic          next_found;
  logic          advance;

`ifdef WAVE_SCHED_TIMEOUT_EN
  localparam int unsigned CW = $clog2(TIMEOUT + 1);
  logic [CW-1:0] wait_cnt_q, wait_cnt_d;
  logic          timeout_q, timeout_d;
  logic          wait_expired;

  assign wait_expired = (wait_cnt_q == CW'(TIMEOUT - 1));
`endif

  // Priority encoders: lowest enabled channel at frame start, and next enabled one above ptr.
  always_comb begin
    first_idx  = '0;
    next_idx   = '0;
    next_found = 1'b0;
    for (int i = int'(N_CH) - 1; i >= 0; i--) begin
      if (ch_enable_i[i]) first_idx = PW'(i);
      if (en_q[i] && (i > int'(ptr_q))) begin
        next_idx   = PW'(i);
        next_found = 1'b1;
      end
    end
  end

  always_comb begin
    state_d   = state_q;
    en_d      = en_q;
    ptr_d     = ptr_q;
    phase_d   = phase_q;
    ampl_d    = ampl_q;
    overrun_d = overrun_q;
    advance   = 1'b0;
    for (int c = 0; c < int'(N_CH); c++) begin
      acc_d[c]  = acc_q[c];
      inc_d[c]  = inc_q[c];
      amp_d[c]  = amp_q[c];
      data_d[c] = data_q[c];
    end
`ifdef WAVE_SCHED_TIMEOUT_EN
    wait_cnt_d = wait_cnt_q;
    timeout_d  = timeout_q;
    if (overrun_clr_i) timeout_d = 1'b0;
`endif
    if (overrun_clr_i) overrun_d = 1'b0;
    if (sample_tick_i && (state_q != StIdle)) overrun_d = 1'b1;

    unique case (state_q)
      StIdle: begin
        if (sample_tick_i) begin
          en_d    = ch_enable_i;
          ptr_d   = first_idx;
          state_d = (|ch_enable_i) ? StIssue : StDone;
        end
      end
      StIssue: begin
        phase_d       = acc_q[ptr_q];
        ampl_d        = amp_q[ptr_q];
        acc_d[ptr_q]  = acc_q[ptr_q] + inc_q[ptr_q];
        state_d       = StWait;
`ifdef WAVE_SCHED_TIMEOUT_EN
        wait_cnt_d    = '0;
`endif
      end
      StWait: begin
        if (dp_valid_strobe_i) begin
          data_d[ptr_q] = dp_data_i;
          advance       = 1'b1;
        end
`ifdef WAVE_SCHED_TIMEOUT_EN
        else if (wait_expired) begin
          timeout_d = 1'b1;
          advance   = 1'b1;
        end else begin
          wait_cnt_d = wait_cnt_q + 1'b1;
        end
`endif
        if (advance) begin
          if (next_found) begin
            ptr_d   = next_idx;
            state_d = StIssue;
          end else begin
            state_d = StDone;
          end
        end
      end
      StDone:  state_d = StIdle;
      default: state_d = StIdle;
    endcase

    // Applied after the ISSUE accumulate so a same-cycle phase clear wins.
    for (int c = 0; c < int'(N_CH); c++) begin
      if (cfg_we_i && (int'(cfg_ch_i) == c)) begin
        inc_d[c] = cfg_phase_inc_i;
        amp_d[c] = cfg_amplitude_i;
        if (cfg_phase_clr_i) acc_d[c] = '0;
      end
    end
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q   <= StIdle;
      en_q      <= '0;
      ptr_q     <= '0;
      phase_q   <= '0;
      ampl_q    <= '0;
      overrun_q <= 1'b0;
      for (int c = 0; c < int'(N_CH); c++) begin
        acc_q[c]  <= '0;
        inc_q[c]  <= '0;
        amp_q[c]  <= '0;
        data_q[c] <= '0;
      end
    end else begin
      state_q   <= state_d;
      en_q      <= en_d;
      ptr_q     <= ptr_d;
      phase_q   <= phase_d;
      ampl_q    <= ampl_d;
      overrun_q <= overrun_d;
      for (int c = 0; c < int'(N_CH); c++) begin
        acc_q[c]  <= acc_d[c];
        inc_q[c]  <= inc_d[c];
        amp_q[c]  <= amp_d[c];
        data_q[c] <= data_d[c];
      end
    end
  end

`ifdef WAVE_SCHED_TIMEOUT_EN
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      wait_cnt_q <= '0;
      timeout_q  <= 1'b0;
    end else begin
      wait_cnt_q <= wait_cnt_d;
      timeout_q  <= timeout_d;
    end
  end
  assign timeout_o = timeout_q;
`else
  assign timeout_o = 1'b0;
`endif

  // Phase/amplitude are live during ISSUE and hold the last issued job otherwise.
  assign dp_start_strobe_o   = (state_q == StIssue);
  assign dp_phase_o          = dp_start_strobe_o ? acc_q[ptr_q] : phase_q;
  assign dp_amplitude_o      = dp_start_strobe_o ? amp_q[ptr_q] : ampl_q;
  assign frame_done_strobe_o = (state_q == StDone);
  assign busy_o              = (state_q != StIdle);
  assign overrun_o           = overrun_q;

  for (genvar c = 0; c < N_CH; c++) begin : g_ch_data
    assign ch_data_o[c*W +: W] = data_q[c];
  end

endmodule

// File: tb/tb_wave_channel_scheduler.sv
// Scoreboard bench for wave_channel_scheduler: expected jobs are queued, a monitor checks each start.
module tb_wave_channel_scheduler;

  localparam int W   = 8;
  localparam int NCH = 4;

  logic           clk = 1'b0;
  logic           rst;
  logic           sample_tick;
  logic [NCH-1:0] ch_enable;
  logic           cfg_we;
  logic [2:0]     cfg_ch;
  logic [W-1:0]   cfg_phase_inc;
  logic [W-1:0]   cfg_amplitude;
  logic           cfg_phase_clr;
  logic           overrun_clr;
  logic [W-1:0]   dp_phase;
  logic [W-1:0]   dp_amplitude;
  logic           dp_start;
  logic [W-1:0]   dp_data;
  logic           dp_valid;
  logic [NCH*W-1:0] ch_data;
  logic           frame_done;
  logic           busy;
  logic           overrun;
  logic           timeout;

  wave_channel_scheduler #(
    .N_FRAC (7),
    .N_CH   (NCH),
    .TIMEOUT(31)
  ) dut (
    .clk_i              (clk),
    .rst_i              (rst),
    .sample_tick_i      (sample_tick),
    .ch_enable_i        (ch_enable),
    .cfg_we_i           (cfg_we),
    .cfg_ch_i           (cfg_ch),
    .cfg_phase_inc_i    (cfg_phase_inc),
    .cfg_amplitude_i    (cfg_amplitude),
    .cfg_phase_clr_i    (cfg_phase_clr),
    .overrun_clr_i      (overrun_clr),
    .dp_phase_o         (dp_phase),
    .dp_amplitude_o     (dp_amplitude),
    .dp_start_strobe_o  (dp_start),
    .dp_data_i          (dp_data),
    .dp_valid_strobe_i  (dp_valid),
    .ch_data_o          (ch_data),
    .frame_done_strobe_o(frame_done),
    .busy_o             (busy),
    .overrun_o          (overrun),
    .timeout_o          (timeout)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc++;

  int vectors = 0;
  int miscompares = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %h, required %h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  typedef struct packed {
    logic [W-1:0] ph;
    logic [W-1:0] amp;
  } job_t;

  job_t exp_q[$];
  job_t mon_e;

  task automatic expect_job(input logic [W-1:0] ph, input logic [W-1:0] amp);
    job_t j;
    j.ph  = ph;
    j.amp = amp;
    exp_q.push_back(j);
  endtask

  // Monitor: every start strobe must match the oldest queued job.
  always @(negedge clk) begin
    if (!rst && dp_start) begin
      if (exp_q.size() == 0) begin
        vectors++;
        miscompares++;
        $display("FAIL unexpected_start: got phase %h amp %h, required no job", dp_phase,
                 dp_amplitude);
      end else begin
        mon_e = exp_q.pop_front();
        check("start_phase", {24'h0, dp_phase}, {24'h0, mon_e.ph});
        check("start_amp", {24'h0, dp_amplitude}, {24'h0, mon_e.amp});
      end
    end
  end

  // Datapath model: 5-cycle latency, result = phase ^ amplitude.
  logic         dp_mute = 1'b0;
  int           dp_cnt = 0;
  logic [W-1:0] dp_ph_l, dp_amp_l;
  int           last_valid_cyc = 0;

  always @(negedge clk) begin
    dp_valid = 1'b0;
    if (rst) begin
      dp_cnt = 0;
    end else begin
      if (dp_cnt > 0) begin
        dp_cnt--;
        if (dp_cnt == 0) begin
          dp_valid       = 1'b1;
          dp_data        = dp_ph_l ^ dp_amp_l;
          last_valid_cyc = cyc;
        end
      end
      if (dp_start && !dp_mute) begin
        dp_ph_l  = dp_phase;
        dp_amp_l = dp_amplitude;
        dp_cnt   = 5;
      end
    end
  end

  task automatic cfg(input logic [2:0] ch, input logic [W-1:0] inc, input logic [W-1:0] amp,
                     input logic clr);
    cfg_we        = 1'b1;
    cfg_ch        = ch;
    cfg_phase_inc = inc;
    cfg_amplitude = amp;
    cfg_phase_clr = clr;
    @(negedge clk);
    cfg_we        = 1'b0;
    cfg_phase_clr = 1'b0;
    @(negedge clk);
  endtask

  // Issues one tick at the current negedge and follows the frame to completion.
  task automatic run_frame(input logic [NCH-1:0] en, input int over_at, input bit race,
                           input logic [31:0] exp_data);
    int done_at = -1;
    ch_enable   = en;
    sample_tick = 1'b1;
    for (int i = 0; i < 400; i++) begin
      @(negedge clk);
      if (i == 0) begin
        sample_tick = 1'b0;
        if (en != '0) begin
          check("first_start_latency", {31'h0, dp_start}, 32'h1);
        end else begin
          check("empty_frame_done", {31'h0, frame_done}, 32'h1);
          check("empty_frame_no_start", {31'h0, dp_start}, 32'h0);
        end
        if (race) begin
          cfg_we        = 1'b1;
          cfg_ch        = 3'd0;
          cfg_phase_inc = 8'h70;
          cfg_amplitude = 8'h40;
          cfg_phase_clr = 1'b1;
        end
      end
      if (i == 1) begin
        cfg_we        = 1'b0;
        cfg_phase_clr = 1'b0;
      end
      if (over_at > 0 && i == over_at) sample_tick = 1'b1;
      if (over_at > 0 && i == over_at + 1) begin
        sample_tick = 1'b0;
        check("overrun_set", {31'h0, overrun}, 32'h1);
      end
      if (frame_done) begin
        if (en != '0) check("done_after_last_valid", cyc, last_valid_cyc + 1);
        done_at = i;
        break;
      end
    end
    if (done_at < 0) begin
      vectors++;
      miscompares++;
      $display("FAIL frame_done_bound: got no frame_done in 400 cycles, required one");
    end
    check("ch_data", ch_data, exp_data);
    @(negedge clk);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: got no finish by 500us, required completion");
    $fatal(1, "watchdog");
  end

  initial begin
    rst           = 1'b1;
    sample_tick   = 1'b0;
    ch_enable     = '0;
    cfg_we        = 1'b0;
    cfg_ch        = '0;
    cfg_phase_inc = '0;
    cfg_amplitude = '0;
    cfg_phase_clr = 1'b0;
    overrun_clr   = 1'b0;
    dp_data       = '0;
    dp_valid      = 1'b0;
    repeat (2) @(negedge clk);
    check("reset_ch_data", ch_data, 32'h0);
    check("reset_busy", {31'h0, busy}, 32'h0);
    check("reset_start", {31'h0, dp_start}, 32'h0);
    check("reset_done", {31'h0, frame_done}, 32'h0);
    check("reset_overrun", {31'h0, overrun}, 32'h0);
    check("reset_timeout", {31'h0, timeout}, 32'h0);
    check("reset_phase", {24'h0, dp_phase}, 32'h0);
    check("reset_amp", {24'h0, dp_amplitude}, 32'h0);
    rst = 1'b0;
    @(negedge clk);

    cfg(3'd0, 8'h08, 8'h7F, 1'b1);
    cfg(3'd1, 8'h10, 8'h7F, 1'b1);
    cfg(3'd2, 8'h20, 8'h7F, 1'b1);
    cfg(3'd3, 8'h40, 8'h7F, 1'b1);
    cfg(3'd4, 8'h55, 8'h11, 1'b1);  // out of range: must not alias channel 0

    // Basic frames
    repeat (4) expect_job(8'h00, 8'h7F);
    run_frame(4'b1111, -1, 1'b0, 32'h7F7F7F7F);
    expect_job(8'h08, 8'h7F);
    expect_job(8'h10, 8'h7F);
    expect_job(8'h20, 8'h7F);
    expect_job(8'h40, 8'h7F);
    run_frame(4'b1111, -1, 1'b0, 32'h3F5F6F77);

    // Sparse enable: ch0/ch2 hold data and accumulators
    expect_job(8'h20, 8'h7F);
    expect_job(8'h80, 8'h7F);
    run_frame(4'b1010, -1, 1'b0, 32'hFF5F5F77);
    expect_job(8'h30, 8'h7F);
    expect_job(8'hC0, 8'h7F);
    run_frame(4'b1010, -1, 1'b0, 32'hBF5F4F77);
    expect_job(8'h10, 8'h7F);
    expect_job(8'h40, 8'h7F);
    expect_job(8'h40, 8'h7F);
    expect_job(8'h00, 8'h7F);
    run_frame(4'b1111, -1, 1'b0, 32'h7F3F3F6F);

    // Wrap
    cfg(3'd0, 8'h70, 8'h7F, 1'b1);
    expect_job(8'h00, 8'h7F);
    run_frame(4'b0001, -1, 1'b0, 32'h7F3F3F7F);
    expect_job(8'h70, 8'h7F);
    run_frame(4'b0001, -1, 1'b0, 32'h7F3F3F0F);
    expect_job(8'hE0, 8'h7F);
    run_frame(4'b0001, -1, 1'b0, 32'h7F3F3F9F);
    expect_job(8'h50, 8'h7F);
    run_frame(4'b0001, -1, 1'b0, 32'h7F3F3F2F);

    // Overrun: tick during WAIT is dropped
    expect_job(8'hC0, 8'h7F);
    run_frame(4'b0001, 3, 1'b0, 32'h7F3F3FBF);
    repeat (3) @(negedge clk);
    check("no_extra_jobs", exp_q.size(), 32'h0);
    check("overrun_sticky", {31'h0, overrun}, 32'h1);
    check("idle_after_overrun", {31'h0, busy}, 32'h0);
    overrun_clr = 1'b1;
    @(negedge clk);
    overrun_clr = 1'b0;
    check("overrun_cleared", {31'h0, overrun}, 32'h0);

    // Empty frame
    run_frame(4'b0000, -1, 1'b0, 32'h7F3F3FBF);

    // Config race in ch0 ISSUE: old amp issued, clear wins over accumulate
    expect_job(8'h30, 8'h7F);
    run_frame(4'b0001, -1, 1'b1, 32'h7F3F3F4F);
    expect_job(8'h00, 8'h40);
    run_frame(4'b0001, -1, 1'b0, 32'h7F3F3F40);

`ifdef WAVE_SCHED_TIMEOUT_EN
    begin : timeout_test
      int seen_done = -1;
      dp_mute = 1'b1;
      expect_job(8'h70, 8'h40);
      ch_enable   = 4'b0001;
      sample_tick = 1'b1;
      for (int i = 0; i < 100; i++) begin
        @(negedge clk);
        if (i == 0) sample_tick = 1'b0;
        if (i == 31) check("timeout_not_early", {31'h0, timeout}, 32'h0);
        if (i == 32) check("timeout_at_wait_31", {31'h0, timeout}, 32'h1);
        if (frame_done) begin
          seen_done = i;
          break;
        end
      end
      check("timeout_frame_done_cycle", seen_done, 32);
      check("timeout_ch_data_kept", ch_data, 32'h7F3F3F40);
      @(negedge clk);
      dp_mute     = 1'b0;
      overrun_clr = 1'b1;
      @(negedge clk);
      overrun_clr = 1'b0;
      check("timeout_cleared", {31'h0, timeout}, 32'h0);
      expect_job(8'hE0, 8'h40);
    end
`else
    check("timeout_tied_low", {31'h0, timeout}, 32'h0);
    expect_job(8'h70, 8'h40);
`endif

    // Async reset mid-WAIT
    ch_enable   = 4'b0001;
    sample_tick = 1'b1;
    @(negedge clk);
    sample_tick = 1'b0;
    @(negedge clk);
    sample_tick = 1'b1;
    @(negedge clk);
    sample_tick = 1'b0;
    check("overrun_before_reset", {31'h0, overrun}, 32'h1);
    check("busy_before_reset", {31'h0, busy}, 32'h1);
    #2 rst = 1'b1;
    #1;
    check("async_rst_ch_data", ch_data, 32'h0);
    check("async_rst_busy", {31'h0, busy}, 32'h0);
    check("async_rst_overrun", {31'h0, overrun}, 32'h0);
    check("async_rst_phase", {24'h0, dp_phase}, 32'h0);
    check("async_rst_amp", {24'h0, dp_amplitude}, 32'h0);
    check("async_rst_start", {31'h0, dp_start}, 32'h0);
    check("async_rst_done", {31'h0, frame_done}, 32'h0);
    @(negedge clk);
    rst = 1'b0;
    repeat (8) @(negedge clk);
    check("idle_after_reset", {31'h0, busy}, 32'h0);
    check("scoreboard_drained", exp_q.size(), 32'h0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
